// File: rtl/music_pkg.sv
// music_pkg: constants and types shared by the song playback path
// (song_reader, note_player, frequency_rom and their benches).
//   NOTE_W / DUR_W / STEP_W : note number, duration (beats), phase step widths
//   NOTE_MSB..NOTE_LSB      : note field of the 16-bit note word
//   DUR_MSB..DUR_LSB        : duration field of the 16-bit note word
//   state_t                 : note_player FSM states
package music_pkg;

    localparam int unsigned NOTE_W   = 6;
    localparam int unsigned DUR_W    = 6;
    localparam int unsigned STEP_W   = 20;

    localparam int unsigned NOTE_MSB = 15;
    localparam int unsigned NOTE_LSB = 10;
    localparam int unsigned DUR_MSB  = 9;
    localparam int unsigned DUR_LSB  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/frequency_rom.sv
// frequency_rom: combinational note-number to sine-table phase-step lookup.
// step = round(f * 2^20 / 48000), f = 440 * 2^((n-49)/12) Hz, 10.10 fixed
// point. Entry 0 is a rest and yields a step of 0.
//   note : note number (NOTE_W bits)
//   step : phase increment (STEP_W bits, saturating)
module frequency_rom
    import music_pkg::*;
(
    input  logic [NOTE_W-1:0] note,
    output logic [STEP_W-1:0] step
);

    localparam int unsigned STEP_MAX = (1 << STEP_W) - 1;

    localparam int unsigned STEP_TABLE [64] = '{
            0,   601,   636,   674,   714,   757,   802,   850,
          900,   954,  1010,  1070,  1134,  1201,  1273,  1349,
         1429,  1514,  1604,  1699,  1800,  1907,  2021,  2141,
         2268,  2403,  2546,  2697,  2858,  3028,  3208,  3398,
         3600,  3815,  4041,  4282,  4536,  4806,  5092,  5395,
         5715,  6055,  6415,  6797,  7201,  7629,  8083,  8563,
         9072,  9612, 10184, 10789, 11431, 12110, 12830, 13593,
        14402, 15258, 16165, 17127, 18145, 19224, 20367, 21578
    };

    always_comb begin
        if (STEP_TABLE[note] > STEP_MAX) begin
            step = '1;
        end else begin
            step = STEP_W'(STEP_TABLE[note]);
        end
    end

endmodule

// File: rtl/note_player.sv
// note_player: consumer of the song_reader note handshake. Latches a note
// word on new_note, converts the note to a phase step, holds it for the
// note's duration in beats and then pulses note_done for one cycle.
//   clk, reset : system clock, synchronous active-high reset
//   play       : global play enable (0 pauses beats and mutes step_size)
//   in_data    : note word [15:10] note, [9:4] duration, [3:0] ignored
//   new_note   : single-cycle load strobe
//   beat       : single-cycle beat tick
//   note_done  : single-cycle pulse when the note's duration has expired
//   step_size  : phase increment for the sine reader
//   busy       : high while a note is playing
module note_player
    import music_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [15:0]       in_data,
    input  logic              new_note,
    input  logic              beat,
    output logic              note_done,
    output logic [STEP_W-1:0] step_size,
    output logic              busy
);

    state_t              state, state_next;
    logic [NOTE_W-1:0]   note_q;
    logic [DUR_W-1:0]    count_q;
    logic [STEP_W-1:0]   step_q;
    logic [STEP_W-1:0]   rom_step;
    logic [NOTE_W-1:0]   rom_note;
    logic [NOTE_W-1:0]   load_note;
    logic [DUR_W-1:0]    load_dur;
    logic                load;
    logic                beat_ok;
    logic                unused_bits;

    assign load_note   = in_data[NOTE_MSB:NOTE_LSB];
    assign load_dur    = in_data[DUR_MSB:DUR_LSB];
    assign unused_bits = &{1'b0, in_data[3:0]};

    // Loads are refused only while a note is playing.
    assign load    = new_note && (state != PLAYING);
    assign beat_ok = beat && play;

    // The ROM looks up the incoming note on a load and the latched note
    // otherwise, so step_q refreshes every cycle yet only changes on a load.
    assign rom_note = load ? load_note : note_q;

    frequency_rom u_frequency_rom (
        .note (rom_note),
        .step (rom_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            note_q  <= '0;
            count_q <= '0;
            step_q  <= '0;
        end else begin
            state  <= state_next;
            step_q <= rom_step;
            if (load) begin
                note_q  <= load_note;
                count_q <= load_dur;
            end else if ((state == PLAYING) && beat_ok) begin
                count_q <= count_q - DUR_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        note_done  = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    state_next = (load_dur == '0) ? DONE : PLAYING;
                end
            end
            PLAYING: begin
                if (beat_ok && (count_q == DUR_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                note_done = 1'b1;
                if (load) begin
                    state_next = (load_dur == '0) ? DONE : PLAYING;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state == PLAYING);
    assign step_size = ((state == PLAYING) && play) ? step_q : '0;

endmodule

// File: tb/tb_note_player.sv
module tb_note_player;
    import music_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              play;
    logic [15:0]       in_data;
    logic              new_note;
    logic              beat;
    logic              note_done;
    logic [STEP_W-1:0] step_size;
    logic              busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    note_player dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .in_data   (in_data),
        .new_note  (new_note),
        .beat      (beat),
        .note_done (note_done),
        .step_size (step_size),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic do_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic load_word(input logic [15:0] w);
        in_data  = w;
        new_note = 1'b1;
        tick();
        new_note = 1'b0;
        in_data  = 16'h0000;
    endtask

    task automatic check_outs(input string tag, input logic exp_busy,
                              input logic [31:0] exp_step, input logic exp_done);
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
        check({tag, "_step"}, {12'd0, step_size}, exp_step);
        check({tag, "_done"}, {31'd0, note_done}, {31'd0, exp_done});
    endtask

    initial begin
        reset    = 1'b1;
        play     = 1'b0;
        in_data  = 16'h0000;
        new_note = 1'b0;
        beat     = 1'b0;
        idle(2);
        check_outs("reset", 1'b0, 0, 1'b0);
        reset = 1'b0;
        play  = 1'b1;
        idle(2);

        // Note 49, 3 beats, beat every 10 cycles.
        load_word(16'hC430);
        check_outs("n49_load", 1'b1, 9612, 1'b0);
        do_beat(); idle(9);
        do_beat(); idle(9);
        check_outs("n49_two_beats", 1'b1, 9612, 1'b0);
        do_beat();
        check_outs("n49_done", 1'b0, 0, 1'b1);
        tick();
        check_outs("n49_after", 1'b0, 0, 1'b0);
        idle(3);

        // Note 37, 2 beats, with a 25-cycle pause spanning 2 dropped beats.
        load_word(16'h9420);
        check_outs("n37_load", 1'b1, 4806, 1'b0);
        do_beat(); idle(4);
        play = 1'b0;
        #1;
        check({"pause_immediate_step"}, {12'd0, step_size}, 0);
        for (int unsigned i = 0; i < 25; i++) begin
            beat = (i == 5 || i == 15);
            tick();
        end
        beat = 1'b0;
        check_outs("pause_end", 1'b1, 0, 1'b0);
        play = 1'b1;
        #1;
        check({"resume_step"}, {12'd0, step_size}, 4806);
        idle(3);
        do_beat();
        check_outs("n37_done", 1'b0, 0, 1'b1);
        idle(3);

        // Rest: note 0, 1 beat.
        load_word(16'h0010);
        check_outs("rest_load", 1'b1, 0, 1'b0);
        idle(5);
        do_beat();
        check_outs("rest_done", 1'b0, 0, 1'b1);
        idle(3);

        // Zero-length note.
        load_word(16'hC400);
        check_outs("dur0_done", 1'b0, 0, 1'b1);
        tick();
        check_outs("dur0_after", 1'b0, 0, 1'b0);

        // Back-to-back zero-length loads give two consecutive note_done cycles.
        load_word(16'hC400);
        check_outs("b2b_first", 1'b0, 0, 1'b1);
        load_word(16'h9400);
        check_outs("b2b_second", 1'b0, 0, 1'b1);
        tick();
        check_outs("b2b_after", 1'b0, 0, 1'b0);

        // new_note during PLAYING is ignored.
        load_word(16'hC430);
        do_beat(); idle(2);
        load_word(16'h9420);
        check_outs("ignore_load", 1'b1, 9612, 1'b0);
        do_beat();
        check_outs("ignore_one_left", 1'b1, 9612, 1'b0);
        do_beat();
        check_outs("ignore_done", 1'b0, 0, 1'b1);
        idle(2);

        // Table end points: note 63 and note 1.
        load_word(16'hFC10);
        check_outs("n63_load", 1'b1, 21578, 1'b0);
        do_beat();
        check_outs("n63_done", 1'b0, 0, 1'b1);
        load_word(16'h0410);
        check_outs("n1_load", 1'b1, 601, 1'b0);
        do_beat();
        idle(2);

        // Reset mid-note.
        load_word(16'h9420);
        do_beat();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_outs("midreset", 1'b0, 0, 1'b0);
        idle(2);
        check_outs("midreset_quiet", 1'b0, 0, 1'b0);

        // Load after reset, then a load coincident with the DONE cycle.
        load_word(16'h0010);
        check_outs("post_reset_load", 1'b1, 0, 1'b0);
        do_beat();
        check_outs("done_cycle", 1'b0, 0, 1'b1);
        load_word(16'hC430);
        check_outs("load_in_done", 1'b1, 9612, 1'b0);
        do_beat(); do_beat(); do_beat();
        check_outs("load_in_done_end", 1'b0, 0, 1'b1);
        tick();
        check_outs("final_idle", 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
